param_controller: RTL and testbench

- Parametrised next-generation controller for the simple processor: program counter, instruction register and control FSM.
- Fetches 16-bit instructions from an external instruction memory through a valid handshake, instead of an embedded ROM.
- Drives the datapath control signals: data-memory address and write enable, register-file addresses, write enable and write-source select, and ALU select.
- Adds over the previous controller: parametrised PC and data-address widths, constant load, jump-if-zero, HALT, and fetch stalls.

---
 rtl/param_controller.sv | 194 +++++++++++++++++++
 tb/tb_param_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/param_controller.sv
// Fetch/decode/execute controller for the simple 16-bit processor.
// Fetches from external instruction memory and drives the datapath.
module param_controller #(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8,
  parameter int RST_PC  = 0
) (
  input  logic               Clk,
  input  logic               Rst,
  output logic [PC_W-1:0]    I_addr,
  input  logic [15:0]        I_data,
  input  logic               I_valid,
  input  logic               Ra_zero,
  output logic [PC_W-1:0]    PC_out,
  output logic [15:0]        IR_out,
  output logic [3:0]         OutState,
  output logic [3:0]         NextState,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_wr,
  output logic [1:0]         RF_s,
  output logic [3:0]         RF_W_addr,
  output logic               RF_W_en,
  output logic [3:0]         RF_Ra_addr,
  output logic [3:0]         RF_Rb_addr,
  output logic [2:0]         Alu_s0,
  output logic [7:0]         RF_W_const,
  output logic               Halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_LOADC  = 4'd9,
    S_JMPZ   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  typedef struct packed {
    logic [DADDR_W-1:0] d_addr;
    logic               d_wr;
    logic [1:0]         rf_s;
    logic [3:0]         w_addr;
    logic               w_en;
    logic [3:0]         ra_addr;
    logic [3:0]         rb_addr;
    logic [2:0]         alu;
    logic [7:0]         w_const;
    logic               halted;
  } ctl_t;

  localparam logic [PC_W-1:0] RST_V = PC_W'(RST_PC);

  state_t            state;
  state_t            nstate;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_nx;
  logic [PC_W-1:0]   jmp_tgt;
  logic [15:0]       ir;
  logic [15:0]       ir_nx;
  ctl_t              ctl;

  // Map an opcode to its execute state; upper opcodes fall into NOOP.
  function automatic state_t op_state(input logic [3:0] op);
    state_t s;
    case (op)
      4'b0000: s = S_NOOP;
      4'b0001: s = S_STORE;
      4'b0010: s = S_LOAD_A;
      4'b0011: s = S_ADD;
      4'b0100: s = S_LOADC;
      4'b0101: s = S_SUB;
      4'b0110: s = S_JMPZ;
      4'b0111: s = S_HALT;
      default: s = S_NOOP;
    endcase
    return s;
  endfunction

  // Moore control word for a given state and instruction.
  function automatic ctl_t decode(input state_t s, input logic [15:0] i);
    ctl_t c;
    c = '0;
    case (s)
      S_STORE: begin
        c.d_addr  = i[DADDR_W-1:0];
        c.ra_addr = i[11:8];
        c.d_wr    = 1'b1;
      end
      S_LOAD_A: begin
        c.d_addr = i[DADDR_W-1:0];
        c.rf_s   = 2'b01;
        c.w_addr = i[11:8];
      end
      S_LOAD_B: begin
        c.d_addr = i[DADDR_W-1:0];
        c.rf_s   = 2'b01;
        c.w_addr = i[11:8];
        c.w_en   = 1'b1;
      end
      S_ADD, S_SUB: begin
        c.w_addr  = i[11:8];
        c.ra_addr = i[7:4];
        c.rb_addr = i[3:0];
        c.alu     = (s == S_ADD) ? 3'b001 : 3'b010;
        c.rf_s    = 2'b00;
        c.w_en    = 1'b1;
      end
      S_LOADC: begin
        c.w_addr  = i[11:8];
        c.w_const = i[7:0];
        c.rf_s    = 2'b10;
        c.w_en    = 1'b1;
      end
      S_JMPZ: begin
        c.ra_addr = i[11:8];
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // PC already points past the JMPZ, so subtract one to land on own+k8.
  assign jmp_tgt = pc + PC_W'({{8{ir[7]}}, ir[7:0]}) - PC_W'(1);

  // Next state, PC and IR.
  always_comb begin
    nstate = state;
    pc_nx  = pc;
    ir_nx  = ir;
    case (state)
      S_INIT: begin
        pc_nx  = RST_V;
        nstate = S_FETCH;
      end
      S_FETCH: begin
        if (I_valid) begin
          ir_nx  = I_data;
          pc_nx  = pc + PC_W'(1);
          nstate = S_DECODE;
        end
      end
      S_DECODE: nstate = op_state(ir[15:12]);
      S_LOAD_A: nstate = S_LOAD_B;
      S_JMPZ: begin
        if (Ra_zero) pc_nx = jmp_tgt;
        nstate = S_FETCH;
      end
      S_HALT:  nstate = S_HALT;
      default: nstate = S_FETCH;
    endcase
  end

  // State, PC, IR and the registered control word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
      ctl   <= '0;
    end else begin
      state <= nstate;
      pc    <= pc_nx;
      ir    <= ir_nx;
      ctl   <= decode(nstate, ir_nx);
    end
  end

  assign I_addr     = pc;
  assign PC_out     = pc;
  assign IR_out     = ir;
  assign OutState   = state;
  assign NextState  = nstate;
  assign D_addr     = ctl.d_addr;
  assign D_wr       = ctl.d_wr;
  assign RF_s       = ctl.rf_s;
  assign RF_W_addr  = ctl.w_addr;
  assign RF_W_en    = ctl.w_en;
  assign RF_Ra_addr = ctl.ra_addr;
  assign RF_Rb_addr = ctl.rb_addr;
  assign Alu_s0     = ctl.alu;
  assign RF_W_const = ctl.w_const;
  assign Halted     = ctl.halted;

endmodule

// File: tb/tb_param_controller.sv
// Directed bench for param_controller with a scoreboard queue
// of expected state/PC/IR/control snapshots per clock.
module tb_param_controller;

  logic        Clk;
  logic        Rst;
  logic [6:0]  I_addr;
  logic [15:0] I_data;
  logic        I_valid;
  logic        Ra_zero;
  logic [6:0]  PC_out;
  logic [15:0] IR_out;
  logic [3:0]  OutState;
  logic [3:0]  NextState;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic [1:0]  RF_s;
  logic [3:0]  RF_W_addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;
  logic [7:0]  RF_W_const;
  logic        Halted;

  param_controller #(
    .PC_W(7),
    .DADDR_W(8),
    .RST_PC(0)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .I_addr(I_addr),
    .I_data(I_data),
    .I_valid(I_valid),
    .Ra_zero(Ra_zero),
    .PC_out(PC_out),
    .IR_out(IR_out),
    .OutState(OutState),
    .NextState(NextState),
    .D_addr(D_addr),
    .D_wr(D_wr),
    .RF_s(RF_s),
    .RF_W_addr(RF_W_addr),
    .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr),
    .Alu_s0(Alu_s0),
    .RF_W_const(RF_W_const),
    .Halted(Halted)
  );

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [35:0] ctl;
  } exp_t;

  exp_t        sb[$];
  int          n_vec;
  int          n_err;
  logic [6:0]  epc;
  logic [15:0] eir;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  function automatic logic [35:0] cv(
    input logic [7:0] da, input logic dw, input logic [1:0] s,
    input logic [3:0] wa, input logic we, input logic [3:0] ra,
    input logic [3:0] rb, input logic [2:0] al, input logic [7:0] k,
    input logic h);
    return {da, dw, s, wa, we, ra, rb, al, k, h};
  endfunction

  task automatic chk(input string tag, input string what,
                     input logic [35:0] got, input logic [35:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s/%s got %0h want %0h", tag, what, got, want);
    end
  endtask

  task automatic go(input string tag, input logic v, input logic [15:0] d,
                    input logic rz, input logic [3:0] st,
                    input logic [35:0] c);
    exp_t e;
    exp_t g;
    I_valid = v;
    I_data  = d;
    Ra_zero = rz;
    e.tag = tag;
    e.st  = st;
    e.pc  = epc;
    e.ir  = eir;
    e.ctl = c;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    g = sb.pop_front();
    chk(g.tag, "state", 36'(OutState), 36'(g.st));
    chk(g.tag, "pc", 36'(PC_out), 36'(g.pc));
    chk(g.tag, "iaddr", 36'(I_addr), 36'(g.pc));
    chk(g.tag, "ir", 36'(IR_out), 36'(g.ir));
    chk(g.tag, "ctl",
        {D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr,
         RF_Rb_addr, Alu_s0, RF_W_const, Halted}, g.ctl);
  endtask

  task automatic fetch(input string tag, input logic [15:0] d);
    epc = epc + 7'd1;
    eir = d;
    go(tag, 1'b1, d, 1'b0, 4'd2, '0);
  endtask

  task automatic ins3(input string tag, input logic [15:0] d,
                      input logic [3:0] st, input logic [35:0] c,
                      input logic rz, input int newpc);
    fetch(tag, d);
    go(tag, 1'b0, 16'h0000, 1'b0, st, c);
    if (newpc >= 0) epc = 7'(newpc);
    go(tag, 1'b0, 16'h0000, rz, 4'd1, '0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    epc     = '0;
    eir     = '0;
    Rst     = 1'b1;
    I_valid = 1'b0;
    I_data  = '0;
    Ra_zero = 1'b0;

    go("rst0", 1'b0, 16'h0000, 1'b0, 4'd0, '0);
    go("rst1", 1'b0, 16'h0000, 1'b0, 4'd0, '0);
    Rst = 1'b0;
    go("init", 1'b1, 16'h0000, 1'b0, 4'd1, '0);
    ins3("nop0", 16'h0000, 4'd3, '0, 1'b0, -1);

    ins3("loadc", 16'h4105, 4'd9,
         cv(8'h00, 0, 2'b10, 4'h1, 1, 4'h0, 4'h0, 3'b000, 8'h05, 0),
         1'b0, -1);
    ins3("add", 16'h3312, 4'd7,
         cv(8'h00, 0, 2'b00, 4'h3, 1, 4'h1, 4'h2, 3'b001, 8'h00, 0),
         1'b0, -1);
    ins3("sub", 16'h5312, 4'd8,
         cv(8'h00, 0, 2'b00, 4'h3, 1, 4'h1, 4'h2, 3'b010, 8'h00, 0),
         1'b0, -1);

    fetch("load", 16'h2A1C);
    go("load_a", 1'b0, 16'h0000, 1'b0, 4'd4,
       cv(8'h1C, 0, 2'b01, 4'hA, 0, 4'h0, 4'h0, 3'b000, 8'h00, 0));
    go("load_b", 1'b0, 16'h0000, 1'b0, 4'd5,
       cv(8'h1C, 0, 2'b01, 4'hA, 1, 4'h0, 4'h0, 3'b000, 8'h00, 0));
    go("load_end", 1'b0, 16'h0000, 1'b0, 4'd1, '0);

    ins3("jmpz_taken", 16'h60FE, 4'd10, '0, 1'b1, 3);
    ins3("store", 16'h1A1C, 4'd6,
         cv(8'h1C, 1, 2'b00, 4'h0, 0, 4'hA, 4'h0, 3'b000, 8'h00, 0),
         1'b0, -1);
    ins3("nop4", 16'h0000, 4'd3, '0, 1'b0, -1);
    ins3("jmpz_not", 16'h60FE, 4'd10, '0, 1'b0, -1);
    ins3("jmpz_fwd", 16'h6379, 4'd10,
         cv(8'h00, 0, 2'b00, 4'h0, 0, 4'h3, 4'h0, 3'b000, 8'h00, 0),
         1'b1, 127);
    ins3("jmpz_wrap", 16'h6002, 4'd10, '0, 1'b1, 1);

    for (int i = 0; i < 5; i++) begin
      I_valid = 1'b0;
      #1;
      chk("stall", "next", 36'(NextState), 36'd1);
      go("stall", 1'b0, 16'hFFFF, 1'b0, 4'd1, '0);
    end
    I_valid = 1'b1;
    #1;
    chk("unstall", "next", 36'(NextState), 36'd2);
    ins3("illegal", 16'hF123, 4'd3, '0, 1'b0, -1);

    fetch("halt", 16'h7000);
    go("halt", 1'b0, 16'h0000, 1'b0, 4'd11,
       cv(8'h00, 0, 2'b00, 4'h0, 0, 4'h0, 4'h0, 3'b000, 8'h00, 1));
    for (int i = 0; i < 20; i++) begin
      go("halted", 1'b1, 16'h4105, 1'b1, 4'd11,
         cv(8'h00, 0, 2'b00, 4'h0, 0, 4'h0, 4'h0, 3'b000, 8'h00, 1));
    end
    Rst = 1'b1;
    epc = '0;
    eir = '0;
    go("rst_halt", 1'b1, 16'h4105, 1'b0, 4'd0, '0);
    Rst = 1'b0;
    go("reinit", 1'b0, 16'h0000, 1'b0, 4'd1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
